// File: rtl/usr_burst_shifter_if.sv
// Handshake/data bundle for usr_burst_shifter: control and operands in,
// register contents and burst status out.
interface usr_burst_shifter_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) ();
  logic             en;
  logic [2:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic             start;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, sin_r, sin_l, pin, start, count,
    input  q, sout_r, sout_l, busy, done
  );

  modport slave (
    input  en, mode, sin_r, sin_l, pin, start, count,
    output q, sout_r, sout_l, busy, done
  );
endinterface

// File: rtl/usr_burst_shifter.sv
// Universal shift register (shift/rotate/arith-shift/load/clear) with a
// counted burst engine that repeats a latched operation N times, then pulses done.
module usr_burst_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input logic               clk,
  input logic               clr_n,
  usr_burst_shifter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_p0, q_nxt;
  logic [2:0]       bmode, bmode_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sr,
    input logic             sl,
    input logic [WIDTH-1:0] p
  );
    logic signed [WIDTH-1:0] s;
    s = signed'(cur);
    case (op)
      OP_HOLD: return cur;
      OP_SHR:  return {sr, cur[WIDTH-1:1]};
      OP_SHL:  return {cur[WIDTH-2:0], sl};
      OP_LOAD: return p;
      OP_ROR:  return {cur[0], cur[WIDTH-1:1]};
      OP_ROL:  return {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ASR:  return $unsigned(s >>> 1);
      OP_CLR:  return '0;
      default: return cur;
    endcase
  endfunction

  // Stage p0: state, burst context and register contents
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state <= IDLE;
      bmode <= OP_HOLD;
      rem   <= '0;
      q_p0  <= '0;
    end else begin
      state <= state_nxt;
      bmode <= bmode_nxt;
      rem   <= rem_nxt;
      q_p0  <= q_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    bmode_nxt = bmode;
    rem_nxt   = rem;
    q_nxt     = q_p0;
    case (state)
      IDLE: begin
        // start wins over en; q is untouched on the accepting edge
        if (bus.start) begin
          if (bus.count != '0) begin
            bmode_nxt = bus.mode;
            rem_nxt   = bus.count;
            state_nxt = RUN;
          end else begin
            state_nxt = DONE;
          end
        end else if (bus.en) begin
          q_nxt = apply_op(bus.mode, q_p0, bus.sin_r, bus.sin_l, bus.pin);
        end
      end
      RUN: begin
        q_nxt   = apply_op(bmode, q_p0, bus.sin_r, bus.sin_l, bus.pin);
        rem_nxt = rem - CNT_W'(1);
        if (rem == CNT_W'(1)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.q      = q_p0;
  assign bus.sout_r = q_p0[0];
  assign bus.sout_l = q_p0[WIDTH-1];
  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);

endmodule

// File: tb/tb_usr_burst_shifter.sv
// Directed-vector bench for usr_burst_shifter with hand-computed expectations.
module tb_usr_burst_shifter;

  logic clk;
  logic clr_n;
  int   n_vec;
  int   n_err;

  usr_burst_shifter_if #(.WIDTH(8), .CNT_W(4)) bus ();

  usr_burst_shifter #(.WIDTH(8), .CNT_W(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    bus.mode = 3'b011;
    bus.pin  = v;
    bus.en   = 1'b1;
    tick();
    bus.en   = 1'b0;
  endtask

  logic [7:0] ser;

  initial begin
    n_vec = 0;
    n_err = 0;
    clr_n     = 1'b0;
    bus.en    = 1'b0;
    bus.mode  = 3'b000;
    bus.sin_r = 1'b0;
    bus.sin_l = 1'b0;
    bus.pin   = 8'h00;
    bus.start = 1'b0;
    bus.count = 4'd0;
    #12;
    chk("rst_q", 32'(bus.q), 32'h00);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_sout_r", 32'(bus.sout_r), 0);
    chk("rst_sout_l", 32'(bus.sout_l), 0);
    clr_n = 1'b1;

    // LOAD then asynchronous clear mid-cycle
    @(posedge clk); #1;
    bus.mode = 3'b011; bus.pin = 8'hA5; bus.en = 1'b1;
    tick();
    bus.en = 1'b0;
    chk("load_a5", 32'(bus.q), 32'hA5);
    chk("sout_l_a5", 32'(bus.sout_l), 1);
    #2 clr_n = 1'b0;
    #1 chk("async_clr", 32'(bus.q), 32'h00);
    clr_n = 1'b1;

    // Direct ROR/ROL
    load(8'h81);
    bus.mode = 3'b100; bus.en = 1'b1;
    tick();
    chk("ror_81", 32'(bus.q), 32'hC0);
    bus.en = 1'b0;
    load(8'h81);
    bus.mode = 3'b101; bus.en = 1'b1;
    tick();
    chk("rol1", 32'(bus.q), 32'h03);
    tick();
    chk("rol2", 32'(bus.q), 32'h06);
    bus.en = 1'b0;
    tick();
    chk("hold_en0", 32'(bus.q), 32'h06);

    // ASR burst, count=3
    load(8'h80);
    bus.mode = 3'b110; bus.count = 4'd3; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("asr_e0_busy", 32'(bus.busy), 1);
    chk("asr_e0_q", 32'(bus.q), 32'h80);
    tick();
    chk("asr_e1_q", 32'(bus.q), 32'hC0);
    chk("asr_e1_busy", 32'(bus.busy), 1);
    tick();
    chk("asr_e2_q", 32'(bus.q), 32'hE0);
    chk("asr_e2_done", 32'(bus.done), 0);
    tick();
    chk("asr_e3_q", 32'(bus.q), 32'hF0);
    chk("asr_e3_busy", 32'(bus.busy), 0);
    chk("asr_e3_done", 32'(bus.done), 1);
    tick();
    chk("asr_e4_done", 32'(bus.done), 0);
    chk("asr_e4_q", 32'(bus.q), 32'hF0);

    // Serialise 0x96 LSB-first
    load(8'h96);
    ser = 8'h96;
    bus.sin_r = 1'b0; bus.mode = 3'b001; bus.count = 4'd8; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ser_bit%0d", i), 32'(bus.sout_r), 32'(ser[i]));
      chk($sformatf("ser_nodone%0d", i), 32'(bus.done), 0);
      tick();
    end
    chk("ser_final_q", 32'(bus.q), 32'h00);
    chk("ser_done", 32'(bus.done), 1);
    tick();
    chk("ser_idle_done", 32'(bus.done), 0);
    chk("ser_idle_busy", 32'(bus.busy), 0);

    // count=0 start: immediate done, no operation
    load(8'h3C);
    bus.mode = 3'b111; bus.count = 4'd0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("c0_q", 32'(bus.q), 32'h3C);
    chk("c0_busy", 32'(bus.busy), 0);
    chk("c0_done", 32'(bus.done), 1);
    tick();
    chk("c0_done_drop", 32'(bus.done), 0);
    chk("c0_q_after", 32'(bus.q), 32'h3C);

    // Latched op immune to mode/en/start changes during RUN
    bus.mode = 3'b101; bus.count = 4'd2; bus.start = 1'b1;
    tick();
    chk("lat_e0_busy", 32'(bus.busy), 1);
    bus.mode = 3'b111; bus.en = 1'b1; bus.count = 4'd1;
    tick();
    chk("lat_e1_q", 32'(bus.q), 32'h78);
    tick();
    chk("lat_e2_q", 32'(bus.q), 32'hF0);
    chk("lat_e2_done", 32'(bus.done), 1);
    tick();
    chk("lat_e3_q", 32'(bus.q), 32'hF0);
    chk("lat_e3_busy", 32'(bus.busy), 0);
    chk("lat_e3_done", 32'(bus.done), 0);
    tick();
    bus.start = 1'b0; bus.en = 1'b0;
    chk("reacc_busy", 32'(bus.busy), 1);
    chk("reacc_q", 32'(bus.q), 32'hF0);
    tick();
    chk("reacc_q_clr", 32'(bus.q), 32'h00);
    chk("reacc_done", 32'(bus.done), 1);
    tick();

    // SHL burst aborted by reset
    load(8'h01);
    bus.mode = 3'b010; bus.sin_l = 1'b1; bus.count = 4'd5; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    chk("abort_e1_q", 32'(bus.q), 32'h03);
    tick();
    chk("abort_e2_q", 32'(bus.q), 32'h07);
    #2 clr_n = 1'b0;
    #1;
    chk("abort_q", 32'(bus.q), 32'h00);
    chk("abort_busy", 32'(bus.busy), 0);
    chk("abort_done", 32'(bus.done), 0);
    tick();
    chk("abort_hold_done", 32'(bus.done), 0);
    clr_n = 1'b1;
    tick();
    chk("post_rst_busy", 32'(bus.busy), 0);
    chk("post_rst_done", 32'(bus.done), 0);
    bus.count = 4'd1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("new_e0_busy", 32'(bus.busy), 1);
    tick();
    chk("new_e1_q", 32'(bus.q), 32'h01);
    chk("new_e1_done", 32'(bus.done), 1);
    chk("new_e1_busy", 32'(bus.busy), 0);
    tick();
    chk("new_e2_done", 32'(bus.done), 0);

    // Maximum burst length completes without rem wrapping
    load(8'h01);
    bus.mode = 3'b101; bus.count = 4'd15; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("max_q", 32'(bus.q), 32'h80);
    chk("max_done", 32'(bus.done), 1);
    tick();
    chk("max_idle_busy", 32'(bus.busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
